// File: rtl/is_queue.sv
// In-order dual-issue queue: a circular buffer of renamed instructions, issued two at
// a time once their physical sources are marked ready in a 64-entry scoreboard.

module is_queue_lane (
  input  logic [63:0] sb,
  input  logic        wb1_valid,
  input  logic [5:0]  wb1_phydst,
  input  logic        wb2_valid,
  input  logic [5:0]  wb2_phydst,
  input  logic [5:0]  rsrc1,
  input  logic [5:0]  rsrc2,
  output logic        rdy
);
  logic r1, r2;

  // A same-cycle writeback counts as ready so the consumer issues without a bubble.
  assign r1 = (rsrc1 == 6'd0) | sb[rsrc1]
            | (wb1_valid & (wb1_phydst == rsrc1)) | (wb2_valid & (wb2_phydst == rsrc1));
  assign r2 = (rsrc2 == 6'd0) | sb[rsrc2]
            | (wb1_valid & (wb1_phydst == rsrc2)) | (wb2_valid & (wb2_phydst == rsrc2));
  assign rdy = r1 & r2;
endmodule

module is_queue #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  output logic        stall,
  input  logic        in1_valid,
  input  logic [8:0]  in1_aluop,
  input  logic [4:0]  in1_rdst,
  input  logic [5:0]  in1_rsrc1,
  input  logic [5:0]  in1_rsrc2,
  input  logic [5:0]  in1_phydst,
  input  logic [31:0] in1_imm,
  input  logic [31:0] in1_pc,
  input  logic        in2_valid,
  input  logic [8:0]  in2_aluop,
  input  logic [4:0]  in2_rdst,
  input  logic [5:0]  in2_rsrc1,
  input  logic [5:0]  in2_rsrc2,
  input  logic [5:0]  in2_phydst,
  input  logic [31:0] in2_imm,
  input  logic [31:0] in2_pc,
  input  logic        wb1_valid,
  input  logic [5:0]  wb1_phydst,
  input  logic        wb2_valid,
  input  logic [5:0]  wb2_phydst,
  input  logic        fu_ready,
  output logic        iss1_valid,
  output logic [8:0]  iss1_aluop,
  output logic [4:0]  iss1_rdst,
  output logic [5:0]  iss1_rsrc1,
  output logic [5:0]  iss1_rsrc2,
  output logic [5:0]  iss1_phydst,
  output logic [31:0] iss1_imm,
  output logic [31:0] iss1_pc,
  output logic        iss2_valid,
  output logic [8:0]  iss2_aluop,
  output logic [4:0]  iss2_rdst,
  output logic [5:0]  iss2_rsrc1,
  output logic [5:0]  iss2_rsrc2,
  output logic [5:0]  iss2_phydst,
  output logic [31:0] iss2_imm,
  output logic [31:0] iss2_pc
);
  localparam int NUM_LANES = 2;
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] STALL_TH = (PW+1)'(DEPTH - 2);
  localparam logic [PW:0] TWO      = (PW+1)'(2);

  typedef struct packed {
    logic [8:0]  aluop;
    logic [4:0]  rdst;
    logic [5:0]  rsrc1;
    logic [5:0]  rsrc2;
    logic [5:0]  phydst;
    logic [31:0] imm;
    logic [31:0] pc;
  } entry_t;

  entry_t                        mem [DEPTH];
  entry_t [NUM_LANES-1:0]        in_e, cand, iss_e;
  logic   [NUM_LANES-1:0]        lane_rdy, iss_go, iss_v;
  logic   [PW-1:0]               head, tail, head_p1, tail_p1;
  logic   [PW:0]                 count;
  logic   [63:0]                 sb, sb_nxt;
  logic   [1:0]                  n_enq, n_deq;
  logic                          enq_go, hazard;

  assign in_e[0] = '{aluop: in1_aluop, rdst: in1_rdst, rsrc1: in1_rsrc1, rsrc2: in1_rsrc2,
                     phydst: in1_phydst, imm: in1_imm, pc: in1_pc};
  assign in_e[1] = '{aluop: in2_aluop, rdst: in2_rdst, rsrc1: in2_rsrc1, rsrc2: in2_rsrc2,
                     phydst: in2_phydst, imm: in2_imm, pc: in2_pc};

  assign head_p1 = head + PW'(1);
  assign tail_p1 = tail + PW'(1);
  assign cand[0] = mem[head];
  assign cand[1] = mem[head_p1];

  // Two free slots are required because upstream may always present a full pair.
  assign stall  = count > STALL_TH;
  assign enq_go = !stall && !flush;
  assign n_enq  = enq_go ? ({1'b0, in1_valid} + {1'b0, in2_valid}) : 2'd0;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    is_queue_lane u_lane (
      .sb(sb), .wb1_valid(wb1_valid), .wb1_phydst(wb1_phydst),
      .wb2_valid(wb2_valid), .wb2_phydst(wb2_phydst),
      .rsrc1(cand[l].rsrc1), .rsrc2(cand[l].rsrc2), .rdy(lane_rdy[l])
    );
  end

  // The younger slot cannot consume the older slot's result in the same issue group.
  assign hazard = (cand[0].phydst != 6'd0) &&
                  ((cand[1].rsrc1 == cand[0].phydst) || (cand[1].rsrc2 == cand[0].phydst));
  assign iss_go[0] = fu_ready && (count != '0) && lane_rdy[0];
  assign iss_go[1] = iss_go[0] && (count >= TWO) && lane_rdy[1] && !hazard;
  assign n_deq     = {1'b0, iss_go[0]} + {1'b0, iss_go[1]};

  // Enqueue clears are applied after writeback sets so they win on a collision.
  always_comb begin
    sb_nxt = sb;
    if (wb1_valid) sb_nxt[wb1_phydst] = 1'b1;
    if (wb2_valid) sb_nxt[wb2_phydst] = 1'b1;
    if (enq_go && in1_valid && in1_phydst != 6'd0) sb_nxt[in1_phydst] = 1'b0;
    if (enq_go && in2_valid && in2_phydst != 6'd0) sb_nxt[in2_phydst] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst && enq_go) begin
      if (in1_valid) mem[tail] <= in_e[0];
      if (in2_valid) mem[in1_valid ? tail_p1 : tail] <= in_e[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      sb    <= '1;
      iss_v <= '0;
      iss_e <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      sb    <= '1;
      iss_v <= '0;
    end else begin
      head  <= head + PW'(n_deq);
      tail  <= tail + PW'(n_enq);
      count <= count + (PW+1)'(n_enq) - (PW+1)'(n_deq);
      sb    <= sb_nxt;
      if (fu_ready) begin
        iss_v <= iss_go;
        iss_e <= cand;
      end
    end
  end

  assign iss1_valid  = iss_v[0];
  assign iss1_aluop  = iss_e[0].aluop;
  assign iss1_rdst   = iss_e[0].rdst;
  assign iss1_rsrc1  = iss_e[0].rsrc1;
  assign iss1_rsrc2  = iss_e[0].rsrc2;
  assign iss1_phydst = iss_e[0].phydst;
  assign iss1_imm    = iss_e[0].imm;
  assign iss1_pc     = iss_e[0].pc;
  assign iss2_valid  = iss_v[1];
  assign iss2_aluop  = iss_e[1].aluop;
  assign iss2_rdst   = iss_e[1].rdst;
  assign iss2_rsrc1  = iss_e[1].rsrc1;
  assign iss2_rsrc2  = iss_e[1].rsrc2;
  assign iss2_phydst = iss_e[1].phydst;
  assign iss2_imm    = iss_e[1].imm;
  assign iss2_pc     = iss_e[1].pc;
endmodule

// File: tb/tb_is_queue.sv
// Bench for is_queue: directed vector table, hand sequences for stall/flush/reset
// corners, and a random run against a queue-based reference model.

module tb_is_queue;
  localparam int DEPTH = 8;

  logic        clk = 1'b0, rst, flush, stall, fu_ready;
  logic        in1_valid, in2_valid, wb1_valid, wb2_valid;
  logic [8:0]  in1_aluop, in2_aluop, iss1_aluop, iss2_aluop;
  logic [4:0]  in1_rdst, in2_rdst, iss1_rdst, iss2_rdst;
  logic [5:0]  in1_rsrc1, in1_rsrc2, in1_phydst, in2_rsrc1, in2_rsrc2, in2_phydst;
  logic [5:0]  iss1_rsrc1, iss1_rsrc2, iss1_phydst, iss2_rsrc1, iss2_rsrc2, iss2_phydst;
  logic [5:0]  wb1_phydst, wb2_phydst;
  logic [31:0] in1_imm, in1_pc, in2_imm, in2_pc, iss1_imm, iss1_pc, iss2_imm, iss2_pc;
  logic        iss1_valid, iss2_valid;

  is_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in1_valid(in1_valid), .in1_aluop(in1_aluop), .in1_rdst(in1_rdst), .in1_rsrc1(in1_rsrc1),
    .in1_rsrc2(in1_rsrc2), .in1_phydst(in1_phydst), .in1_imm(in1_imm), .in1_pc(in1_pc),
    .in2_valid(in2_valid), .in2_aluop(in2_aluop), .in2_rdst(in2_rdst), .in2_rsrc1(in2_rsrc1),
    .in2_rsrc2(in2_rsrc2), .in2_phydst(in2_phydst), .in2_imm(in2_imm), .in2_pc(in2_pc),
    .wb1_valid(wb1_valid), .wb1_phydst(wb1_phydst), .wb2_valid(wb2_valid), .wb2_phydst(wb2_phydst),
    .fu_ready(fu_ready),
    .iss1_valid(iss1_valid), .iss1_aluop(iss1_aluop), .iss1_rdst(iss1_rdst), .iss1_rsrc1(iss1_rsrc1),
    .iss1_rsrc2(iss1_rsrc2), .iss1_phydst(iss1_phydst), .iss1_imm(iss1_imm), .iss1_pc(iss1_pc),
    .iss2_valid(iss2_valid), .iss2_aluop(iss2_aluop), .iss2_rdst(iss2_rdst), .iss2_rsrc1(iss2_rsrc1),
    .iss2_rsrc2(iss2_rsrc2), .iss2_phydst(iss2_phydst), .iss2_imm(iss2_imm), .iss2_pc(iss2_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Opaque per-instruction fields are derived from pc so any datapath mixup shows.
  function automatic logic [8:0]  f_aluop(input logic [31:0] pc); return pc[10:2]; endfunction
  function automatic logic [4:0]  f_rdst (input logic [31:0] pc); return pc[6:2] ^ 5'h15; endfunction
  function automatic logic [31:0] f_imm  (input logic [31:0] pc); return ~pc; endfunction

  task automatic drive(input int slot, input logic v, input logic [5:0] s1, input logic [5:0] s2,
                       input logic [5:0] pd, input logic [31:0] pc);
    if (slot == 1) begin
      in1_valid = v; in1_rsrc1 = s1; in1_rsrc2 = s2; in1_phydst = pd; in1_pc = pc;
      in1_aluop = f_aluop(pc); in1_rdst = f_rdst(pc); in1_imm = f_imm(pc);
    end else begin
      in2_valid = v; in2_rsrc1 = s1; in2_rsrc2 = s2; in2_phydst = pd; in2_pc = pc;
      in2_aluop = f_aluop(pc); in2_rdst = f_rdst(pc); in2_imm = f_imm(pc);
    end
  endtask

  task automatic idle();
    drive(1, 1'b0, 6'd0, 6'd0, 6'd0, 32'd0);
    drive(2, 1'b0, 6'd0, 6'd0, 6'd0, 32'd0);
    wb1_valid = 1'b0; wb1_phydst = 6'd0; wb2_valid = 1'b0; wb2_phydst = 6'd0; flush = 1'b0;
  endtask

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic do_reset();
    idle(); fu_ready = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic chk_iss(input string nm, input logic ev1, input logic [31:0] ep1,
                         input logic ev2, input logic [31:0] ep2);
    chk({nm, ".v1"}, 64'(iss1_valid), 64'(ev1));
    if (ev1) begin
      chk({nm, ".pc1"}, 64'(iss1_pc), 64'(ep1));
      chk({nm, ".f1"}, 64'({iss1_aluop, iss1_rdst, iss1_imm}), 64'({f_aluop(ep1), f_rdst(ep1), f_imm(ep1)}));
    end
    chk({nm, ".v2"}, 64'(iss2_valid), 64'(ev2));
    if (ev2) begin
      chk({nm, ".pc2"}, 64'(iss2_pc), 64'(ep2));
      chk({nm, ".f2"}, 64'({iss2_aluop, iss2_rdst, iss2_imm}), 64'({f_aluop(ep2), f_rdst(ep2), f_imm(ep2)}));
    end
  endtask

  typedef struct {
    logic v1; logic [5:0] a1, b1, d1; logic [31:0] pc1;
    logic v2; logic [5:0] a2, b2, d2; logic [31:0] pc2;
    logic wbv; logic [5:0] wbd; logic fu;
    logic e_v1; logic [31:0] e_pc1; logic e_v2; logic [31:0] e_pc2;
  } vec_t;

  function automatic vec_t mk(input int v1, a1, b1, d1, pc1, v2, a2, b2, d2, pc2,
                              wbv, wbd, fu, ev1, epc1, ev2, epc2);
    vec_t r;
    r.v1 = 1'(v1); r.a1 = 6'(a1); r.b1 = 6'(b1); r.d1 = 6'(d1); r.pc1 = 32'(pc1);
    r.v2 = 1'(v2); r.a2 = 6'(a2); r.b2 = 6'(b2); r.d2 = 6'(d2); r.pc2 = 32'(pc2);
    r.wbv = 1'(wbv); r.wbd = 6'(wbd); r.fu = 1'(fu);
    r.e_v1 = 1'(ev1); r.e_pc1 = 32'(epc1); r.e_v2 = 1'(ev2); r.e_pc2 = 32'(epc2);
    return r;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [5:0] s1, s2, pd; logic [31:0] pc; } ment_t;
  ment_t q[$];
  bit    mrdy[64];
  logic  mv1, mv2;
  ment_t me1, me2;

  function automatic bit m_ok(input logic [5:0] s);
    return (s == 6'd0) || mrdy[s] || (wb1_valid && wb1_phydst == s) || (wb2_valid && wb2_phydst == s);
  endfunction

  task automatic model_reset();
    q.delete(); mv1 = 1'b0; mv2 = 1'b0;
    foreach (mrdy[i]) mrdy[i] = 1'b1;
  endtask

  // One clock of the model from the inputs currently driven; returns whether input was taken.
  task automatic model_step(input ment_t g1, input ment_t g2, output bit acc);
    int sz;
    bit i1, i2;
    sz  = q.size();
    acc = (DEPTH - sz) >= 2;
    if (fu_ready) begin
      i1 = (sz >= 1) && m_ok(q[0].s1) && m_ok(q[0].s2);
      i2 = i1 && (sz >= 2) && m_ok(q[1].s1) && m_ok(q[1].s2) &&
           !(q[0].pd != 6'd0 && (q[1].s1 == q[0].pd || q[1].s2 == q[0].pd));
      mv1 = i1; mv2 = i2;
      if (i1) me1 = q.pop_front();
      if (i2) me2 = q.pop_front();
    end
    if (wb1_valid) mrdy[wb1_phydst] = 1'b1;
    if (wb2_valid) mrdy[wb2_phydst] = 1'b1;
    if (acc) begin
      if (in1_valid) begin q.push_back(g1); if (g1.pd != 6'd0) mrdy[g1.pd] = 1'b0; end
      if (in2_valid) begin q.push_back(g2); if (g2.pd != 6'd0) mrdy[g2.pd] = 1'b0; end
    end
  endtask

  vec_t  tbl[17];
  ment_t g1, g2;
  logic  gv1, gv2;
  bit    acc, prev_acc;
  int    n_acc, n_iss;
  logic [31:0] pcnt, last_pc;

  initial begin
    tbl[0]  = mk(1,3,4,10,'h100, 1,10,0,11,'h104, 0,0, 1, 0,0,     0,0);
    tbl[1]  = mk(0,0,0,0,0,      0,0,0,0,0,       0,0, 1, 1,'h100, 0,0);
    tbl[2]  = mk(0,0,0,0,0,      0,0,0,0,0,       0,0, 1, 0,0,     0,0);
    tbl[3]  = mk(0,0,0,0,0,      0,0,0,0,0,       1,10,1, 1,'h104, 0,0);
    tbl[4]  = mk(0,0,0,0,0,      0,0,0,0,0,       0,0, 1, 0,0,     0,0);
    tbl[5]  = mk(1,0,0,12,'h200, 0,0,0,0,0,       0,0, 1, 0,0,     0,0);
    tbl[6]  = mk(0,0,0,0,0,      0,0,0,0,0,       0,0, 1, 1,'h200, 0,0);
    tbl[7]  = mk(1,0,0,13,'h300, 0,0,0,0,0,       0,0, 0, 1,'h200, 0,0);
    tbl[8]  = mk(0,0,0,0,0,      0,0,0,0,0,       0,0, 0, 1,'h200, 0,0);
    tbl[9]  = mk(0,0,0,0,0,      0,0,0,0,0,       0,0, 1, 1,'h300, 0,0);
    tbl[10] = mk(1,0,0,14,'h400, 1,5,0,16,'h404,  0,0, 1, 0,0,     0,0);
    tbl[11] = mk(0,0,0,0,0,      0,0,0,0,0,       0,0, 1, 1,'h400, 1,'h404);
    tbl[12] = mk(1,0,0,15,'h500, 1,15,0,17,'h504, 0,0, 1, 0,0,     0,0);
    tbl[13] = mk(0,0,0,0,0,      0,0,0,0,0,       1,15,1, 1,'h500, 0,0);
    tbl[14] = mk(0,0,0,0,0,      0,0,0,0,0,       0,0, 1, 1,'h504, 0,0);
    tbl[15] = mk(0,0,0,0,0,      1,0,0,18,'h600,  0,0, 1, 0,0,     0,0);
    tbl[16] = mk(0,0,0,0,0,      0,0,0,0,0,       0,0, 1, 1,'h600, 0,0);

    rst = 1'b1; fu_ready = 1'b0; idle();
    do_reset();
    chk("rst.stall", 64'(stall), 64'd0);
    chk("rst.valid", 64'({iss1_valid, iss2_valid}), 64'd0);
    chk("rst.fields", 64'({iss1_pc, iss2_imm}), 64'd0);
    chk("rst.fields2", 64'({iss1_aluop, iss1_rdst, iss1_phydst, iss2_rsrc1, iss2_rsrc2}), 64'd0);

    // Directed vectors: bypass, hold on fu_ready=0, dual issue, intra-pair hazard.
    for (int i = 0; i < 17; i++) begin
      drive(1, tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].d1, tbl[i].pc1);
      drive(2, tbl[i].v2, tbl[i].a2, tbl[i].b2, tbl[i].d2, tbl[i].pc2);
      wb1_valid = tbl[i].wbv; wb1_phydst = tbl[i].wbd; fu_ready = tbl[i].fu;
      tick();
      chk_iss($sformatf("vec%0d", i), tbl[i].e_v1, tbl[i].e_pc1, tbl[i].e_v2, tbl[i].e_pc2);
      chk($sformatf("vec%0d.stall", i), 64'(stall), 64'd0);
    end
    idle();

    // Fill to 7 with fu_ready low, then drain two per cycle; stalled input is dropped.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1'b1, 6'd0, 6'd0, 6'(20 + 2*k), 32'h1000 + 32'(8*k));
      drive(2, 1'b1, 6'd0, 6'd0, 6'(21 + 2*k), 32'h1004 + 32'(8*k));
      tick();
      chk($sformatf("fill%0d.stall", k), 64'(stall), 64'd0);
    end
    drive(1, 1'b1, 6'd0, 6'd0, 6'd26, 32'h1018); drive(2, 1'b0, 6'd0, 6'd0, 6'd0, 32'd0);
    tick();
    chk("fill7.stall", 64'(stall), 64'd1);
    drive(1, 1'b1, 6'd0, 6'd0, 6'd27, 32'h900); drive(2, 1'b1, 6'd0, 6'd0, 6'd28, 32'h904);
    tick();
    chk("full_hold.stall", 64'(stall), 64'd1);
    chk("full_hold.v1", 64'(iss1_valid), 64'd0);
    fu_ready = 1'b1;
    tick();
    chk_iss("drain0", 1'b1, 32'h1000, 1'b1, 32'h1004);
    chk("drain0.stall", 64'(stall), 64'd0);
    idle();
    tick(); chk_iss("drain1", 1'b1, 32'h1008, 1'b1, 32'h100C);
    tick(); chk_iss("drain2", 1'b1, 32'h1010, 1'b1, 32'h1014);
    tick(); chk_iss("drain3", 1'b1, 32'h1018, 1'b0, 32'h0);
    tick(); chk_iss("drain4", 1'b0, 32'h0, 1'b0, 32'h0);

    // Enqueue clear beats writeback set on the same bit.
    do_reset(); fu_ready = 1'b1;
    drive(1, 1'b1, 6'd0, 6'd0, 6'd20, 32'h2000); wb2_valid = 1'b1; wb2_phydst = 6'd20;
    tick();
    idle(); drive(1, 1'b1, 6'd20, 6'd0, 6'd21, 32'h2004);
    tick(); chk_iss("sbprio.prod", 1'b1, 32'h2000, 1'b0, 32'h0);
    idle();
    for (int k = 0; k < 3; k++) begin
      tick(); chk($sformatf("sbprio.blk%0d", k), 64'(iss1_valid), 64'd0);
    end
    wb1_valid = 1'b1; wb1_phydst = 6'd20;
    tick(); chk_iss("sbprio.wake", 1'b1, 32'h2004, 1'b0, 32'h0);
    idle();

    // Flush with five entries queued and issue registers valid.
    do_reset();
    drive(1, 1'b1, 6'd0, 6'd0, 6'd30, 32'h3000); drive(2, 1'b1, 6'd0, 6'd0, 6'd31, 32'h3004);
    tick();
    drive(1, 1'b1, 6'd0, 6'd0, 6'd32, 32'h3008); drive(2, 1'b1, 6'd0, 6'd0, 6'd33, 32'h300C);
    fu_ready = 1'b1;
    tick(); chk_iss("fl.pre", 1'b1, 32'h3000, 1'b1, 32'h3004);
    drive(1, 1'b1, 6'd0, 6'd0, 6'd34, 32'h3010); drive(2, 1'b1, 6'd0, 6'd0, 6'd35, 32'h3014);
    fu_ready = 1'b0;
    tick();
    drive(1, 1'b1, 6'd0, 6'd0, 6'd36, 32'h3018); drive(2, 1'b0, 6'd0, 6'd0, 6'd0, 32'd0);
    tick(); chk("fl.held", 64'(iss1_valid), 64'd1);
    drive(1, 1'b1, 6'd0, 6'd0, 6'd37, 32'h3800); drive(2, 1'b1, 6'd0, 6'd0, 6'd38, 32'h3804);
    flush = 1'b1; fu_ready = 1'b1;
    tick();
    chk_iss("fl.post", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("fl.stall", 64'(stall), 64'd0);
    idle(); drive(1, 1'b1, 6'd32, 6'd34, 6'd40, 32'h3100);
    tick(); chk_iss("fl.empty", 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    tick(); chk_iss("fl.sbready", 1'b1, 32'h3100, 1'b0, 32'h0);

    // Reset mid-operation discards queued work without a partial issue.
    do_reset(); fu_ready = 1'b1;
    drive(1, 1'b1, 6'd0, 6'd0, 6'd41, 32'h4000); drive(2, 1'b1, 6'd0, 6'd0, 6'd42, 32'h4004);
    tick();
    idle(); rst = 1'b1;
    tick();
    chk("mrst.valid", 64'({iss1_valid, iss2_valid}), 64'd0);
    chk("mrst.pc", 64'({iss1_pc, iss2_pc}), 64'd0);
    chk("mrst.stall", 64'(stall), 64'd0);
    rst = 1'b0;
    tick(); chk("mrst.after", 64'({iss1_valid, iss2_valid}), 64'd0);

    // Random traffic against the model, crossing the pointer wrap many times.
    do_reset(); model_reset();
    prev_acc = 1'b1; pcnt = 32'h8000; last_pc = 32'h0; n_acc = 0; n_iss = 0;
    gv1 = 1'b0; gv2 = 1'b0; g1 = '{6'd0, 6'd0, 6'd0, 32'd0}; g2 = g1;
    for (int c = 0; c < 460; c++) begin
      if (c < 400) begin
        if (prev_acc) begin
          gv1 = ($urandom_range(0, 3) != 0); gv2 = ($urandom_range(0, 3) != 0);
          g1 = '{6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)), pcnt};
          if (gv1) pcnt = pcnt + 32'd4;
          g2 = '{6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)), pcnt};
          if (gv2) pcnt = pcnt + 32'd4;
        end
        fu_ready  = ($urandom_range(0, 3) != 0);
        wb1_valid = $urandom_range(0, 1) != 0; wb1_phydst = 6'($urandom_range(1, 15));
        wb2_valid = $urandom_range(0, 1) != 0; wb2_phydst = 6'($urandom_range(1, 15));
      end else begin
        gv1 = 1'b0; gv2 = 1'b0; fu_ready = 1'b1;
        wb1_valid = 1'b1; wb1_phydst = 6'(c % 15 + 1);
        wb2_valid = 1'b1; wb2_phydst = 6'((c + 7) % 15 + 1);
      end
      drive(1, gv1, g1.s1, g1.s2, g1.pd, g1.pc);
      drive(2, gv2, g2.s1, g2.s2, g2.pd, g2.pc);
      model_step(g1, g2, acc);
      if (acc) n_acc += int'(gv1) + int'(gv2);
      prev_acc = acc;
      tick();
      chk($sformatf("r%0d.stall", c), 64'(stall), 64'((DEPTH - q.size()) < 2));
      chk($sformatf("r%0d.v", c), 64'({iss1_valid, iss2_valid}), 64'({mv1, mv2}));
      if (mv1) chk($sformatf("r%0d.e1", c), 64'({iss1_pc, iss1_rsrc1, iss1_rsrc2, iss1_phydst}),
                   64'({me1.pc, me1.s1, me1.s2, me1.pd}));
      if (mv2) chk($sformatf("r%0d.e2", c), 64'({iss2_pc, iss2_rsrc1, iss2_rsrc2, iss2_phydst}),
                   64'({me2.pc, me2.s1, me2.s2, me2.pd}));
      if (fu_ready && iss1_valid) begin
        n_iss++;
        chk($sformatf("r%0d.order1", c), 64'(iss1_pc > last_pc), 64'd1);
        last_pc = iss1_pc;
      end
      if (fu_ready && iss2_valid) begin
        n_iss++;
        chk($sformatf("r%0d.order2", c), 64'(iss2_pc > last_pc), 64'd1);
        last_pc = iss2_pc;
      end
    end
    chk("rand.no_loss", 64'(n_iss), 64'(n_acc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/is_queue.md
IS_QUEUE -- requirements
Module: is_queue

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high (clk rising edge).
REQ-002 SHALL have: flush  in  1  pipeline flush; stall  out  1  backpressure to the decode/issue pipeline register.
REQ-003 SHALL have, for x in {1,2}: inx_valid in 1; inx_aluop in 9; inx_rdst in 5; inx_rsrc1, inx_rsrc2, inx_phydst in 6 each; inx_imm in 32; inx_pc in 32. Slot 1 is older than slot 2.
REQ-004 SHALL have, for x in {1,2}: wbx_valid in 1; wbx_phydst in 6 (writeback of physical register).
REQ-005 SHALL have: fu_ready in 1 (functional units accept the issue registers this cycle).
REQ-006 SHALL have, for x in {1,2}: issx_valid out 1; issx_aluop out 9; issx_rdst out 5; issx_rsrc1, issx_rsrc2, issx_phydst out 6; issx_imm out 32; issx_pc out 32. All are registered.
REQ-007 SHALL have parameter DEPTH, default 8, meaning queue entries (power of two, >=4).

Function
REQ-008 SHALL hold entries in a circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping DEPTH-1 -> 0, and a count of 0..DEPTH.
REQ-009 SHALL drive stall = 1 combinationally when (DEPTH - count) < 2, evaluated from the registered count.
REQ-010 SHALL enqueue when stall=0: valid slots are written compacted in order (in1 at tail, in2 at tail+1; if only in2 is valid, in2 at tail); tail and count advance by the number of valid slots.
REQ-011 SHALL ignore in1/in2 when stall=1 (upstream holds them).
REQ-012 SHALL keep a 64-bit ready scoreboard: an enqueued valid instruction with phydst != 0 clears bit phydst; wbx_valid sets bit wbx_phydst; bit 0 reads as ready at all times.
REQ-013 SHALL give the enqueue clear priority over a writeback set to the same bit in the same cycle.
REQ-014 SHALL treat a source as ready if its scoreboard bit is 1 or it matches a same-cycle wbx_phydst with wbx_valid=1 (bypass).
REQ-015 SHALL issue strictly in order. Head issues when fu_ready=1, count>=1, and both head sources are ready.
REQ-016 SHALL issue entry head+1 in the same cycle only if the head issues, count>=2, both its sources are ready, and neither source equals the head's phydst (phydst 0 exempt).
REQ-017 On an issue cycle, issx_* SHALL load the issuing entries; issx_valid=0 for slots that do not issue. Head advances and count decreases by 0, 1 or 2.
REQ-018 When fu_ready=0, issx_* SHALL hold their values and no entry SHALL dequeue.
REQ-019 When fu_ready=1 and nothing issues, iss1_valid and iss2_valid SHALL be 0.
REQ-020 An entry written at edge N SHALL be eligible to issue at edge N+1 at the earliest; it appears on issx at edge N+1. Minimum latency from in to iss is 2 edges.
REQ-021 On simultaneous enqueue and dequeue, the next count SHALL be count + enq - deq. A full queue with a 2-wide dequeue still asserts stall in that cycle.
REQ-022 Flush SHALL take priority over enqueue, issue and writeback: head=tail=count=0, iss1_valid=iss2_valid=0, all scoreboard bits set to 1.
REQ-023 The queue contents SHALL NOT overflow: enqueue never occurs with fewer than 2 free entries.

Reset
REQ-024 While rst=1 at a clk edge, the block SHALL apply the REQ-022 state and SHALL force all issx_* fields to 0. stall SHALL read 0 after reset.
REQ-025 rst SHALL override flush and all inputs. Reset in the middle of operation SHALL discard all entries with no partial issue.

Verification
REQ-026 Reset, then in1 (rsrc1=3, rsrc2=4, phydst=10, pc=0x100) and in2 (rsrc1=10, phydst=11, pc=0x104), fu_ready=1 -> iss1 pc=0x100 two edges later with iss2_valid=0; in2 issues only after wb1_valid=1, wb1_phydst=10 (bypass same cycle).
REQ-027 Fill with 7 independent entries while fu_ready=0 -> stall=1 at count=7; release fu_ready -> two entries dequeue per cycle and stall drops when count<=6.
REQ-028 Enqueue phydst=20 and writeback wb2_phydst=20 in the same cycle -> scoreboard bit 20 = 0; a consumer of 20 does not issue.
REQ-029 Push 12 pairs through DEPTH=8 with random fu_ready -> issue order equals enqueue pc order across pointer wrap, and there is no loss or duplication.
REQ-030 Flush with count=5 and iss valid -> next cycle count=0, iss1_valid=iss2_valid=0, stall=0, all scoreboard bits ready; an enqueue presented on the flush cycle is dropped.
